// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute pipeline boundary.
// Holds ALU opcodes, datapath widths and the ID/EX register bundle.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    typedef struct packed {
        logic              valid;
        logic [2:0]        aluop;
        logic [REG_AW-1:0] rs_idx;
        logic [REG_AW-1:0] rt_idx;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic              alusrc;
        logic [REG_AW-1:0] rd_idx;
        logic              regwr;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: EX/MEM beats MEM/WB beats the register-file value.
// Latency: combinational. Backpressure: none, pure select.
// Register 0 is hard-wired and never bypassed.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exmem_regwr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] sel_val
);

    logic idx_nz;

    assign idx_nz = (idx != '0);

    always_comb begin
        sel_val = reg_val;
        if (exmem_regwr && (exmem_rd == idx) && idx_nz) begin
            sel_val = exmem_result;
        end else if (memwb_regwr && (memwb_rd == idx) && idx_nz) begin
            sel_val = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall/flush and RAW bypassing.
// Latency: one cycle from decode inputs to ex_*; bypass is combinational.
// Backpressure: stall holds the register, flush loads a bubble (flush wins).
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        id_aluop,
    input  logic [REG_AW-1:0] id_rs_idx,
    input  logic [REG_AW-1:0] id_rt_idx,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic [REG_AW-1:0] id_rd_idx,
    input  logic              id_regwr,
    input  logic              exmem_regwr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [2:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_idx,
    output logic              ex_regwr
);

    id_ex_t            stage_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // An all-zero bundle is the bubble: invalid, no write, ALU_ADD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (!stall) begin
            stage_q.valid  <= id_valid;
            stage_q.aluop  <= id_aluop;
            stage_q.rs_idx <= id_rs_idx;
            stage_q.rt_idx <= id_rt_idx;
            stage_q.rs_val <= id_rs_val;
            stage_q.rt_val <= id_rt_val;
            stage_q.imm    <= id_imm;
            stage_q.alusrc <= id_alusrc;
            stage_q.rd_idx <= id_rd_idx;
            stage_q.regwr  <= id_regwr & id_valid;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx          (stage_q.rs_idx),
        .reg_val      (stage_q.rs_val),
        .exmem_regwr  (exmem_regwr),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_regwr  (memwb_regwr),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .sel_val      (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx          (stage_q.rt_idx),
        .reg_val      (stage_q.rt_val),
        .exmem_regwr  (exmem_regwr),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_regwr  (memwb_regwr),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .sel_val      (fwd_rt)
    );

    assign ex_valid      = stage_q.valid;
    assign ex_aluop      = stage_q.aluop;
    assign ex_a          = fwd_rs;
    assign ex_b          = stage_q.alusrc ? stage_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_rd_idx     = stage_q.rd_idx;
    assign ex_regwr      = stage_q.regwr & stage_q.valid;

endmodule
